// File: rtl/top_pkg.sv
// Shared types and reset/trap defaults for the branch-target PC block.
// Imported by the interface, the PC register top and the statistics sub-module.
// Optional statistics are selected elsewhere with BRANCH_STATS_EN.
package top_pkg;

  typedef logic [15:0] word_t;

  localparam word_t RESET_PC_DEF    = 16'h0000;
  localparam word_t TRAP_VECTOR_DEF = 16'h0004;

endpackage

// File: rtl/top_if.sv
// Branch-target bus: target into the PC block, current PC back out.
// Latency: none (plain wires); the PC block registers din by one cycle.
// Backpressure: none, a new target is accepted every cycle.
interface top_if;
  import top_pkg::*;

  word_t din;
  word_t dout;

  modport master (output din, input dout);
  modport slave  (input din, output dout);
endinterface

// File: rtl/branch_stats.sv
// Counts taken jumps and trap loads; both counters wrap from 16'hFFFF to 0.
// Latency: counts update on the same edge as the PC load they describe.
// Backpressure: none; only built when BRANCH_STATS_EN is defined.
module branch_stats
  import top_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  jump,
  input  logic  trap,
  output word_t jump_count,
  output word_t trap_count
);

  // Event counters, cleared asynchronously by reset, natural 16-bit wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      jump_count <= '0;
      trap_count <= '0;
    end else begin
      if (jump) jump_count <= jump_count + 16'd1;
      if (trap) trap_count <= trap_count + 16'd1;
    end
  end

endmodule

// File: rtl/top.sv
// PC register loaded every cycle from din; a zero target loads TRAP_VECTOR instead.
// Latency: one cycle from din to PC/dout; dout is the register itself.
// Backpressure: none. Optional jump/trap counters compiled in with BRANCH_STATS_EN.
module top
  import top_pkg::*;
#(
  parameter word_t RESET_PC    = RESET_PC_DEF,
  parameter word_t TRAP_VECTOR = TRAP_VECTOR_DEF
) (
  input  logic  clk,
  input  logic  sys_rst,
  input  word_t din,
  output word_t dout
);

  word_t PC;
  word_t last_target;
  logic  trap_seen;
  logic  is_trap;

  // Only a zero target is illegal; TRAP_VECTOR itself is an ordinary jump.
  assign is_trap = (din == 16'h0000);

  // PC load, sticky trap flag and last taken target; reset wins over any update.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      PC          <= RESET_PC;
      trap_seen   <= 1'b0;
      last_target <= '0;
    end else if (is_trap) begin
      PC        <= TRAP_VECTOR;
      trap_seen <= 1'b1;
    end else begin
      PC          <= din;
      last_target <= din;
    end
  end

  assign dout = PC;

`ifdef BRANCH_STATS_EN
  word_t jump_count;
  word_t trap_count;

  branch_stats u_stats (
    .clk        (clk),
    .rst        (sys_rst),
    .jump       (!is_trap),
    .trap       (is_trap),
    .jump_count (jump_count),
    .trap_count (trap_count)
  );
`endif

endmodule

// File: tb/tb_top.sv
// Self-checking bench for top: vector table plus reset corner sequences.
// Expected PC/flag/last-target values are queued when din is driven and
// popped one edge later when the DUT has produced them.
`timescale 1ns/1ps
module tb_top;
  import top_pkg::*;

  typedef struct {
    word_t pc;
    logic  trap;
    word_t last;
  } exp_t;

  typedef struct {
    word_t din;
    exp_t  exp;
  } vec_t;

  logic clk;
  logic sys_rst;
  top_if bus ();

  int n_checks;
  int n_fail;
  exp_t sb_q[$];
  vec_t vecs[8];

  top dut (
    .clk     (clk),
    .sys_rst (sys_rst),
    .din     (bus.din),
    .dout    (bus.dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check16(input string name, input word_t act, input word_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input word_t d, input word_t pc, input logic tr, input word_t last);
    vec_t v;
    v.din      = d;
    v.exp.pc   = pc;
    v.exp.trap = tr;
    v.exp.last = last;
    return v;
  endfunction

  // Drive one target, queue its expectation, compare after the next edge.
  task automatic apply(input string name, input word_t d, input exp_t e);
    exp_t got;
    bus.din = d;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, got 0 entries expected 1", name);
    end else begin
      n_checks--;
      got = sb_q.pop_front();
      check16({name, ".pc"},   dut.PC,          got.pc);
      check16({name, ".dout"}, bus.dout,        got.pc);
      check1 ({name, ".trap"}, dut.trap_seen,   got.trap);
      check16({name, ".last"}, dut.last_target, got.last);
    end
  endtask

  initial begin
    exp_t e;
    n_checks = 0;
    n_fail   = 0;

    vecs[0] = mk(16'h0010, 16'h0010, 1'b0, 16'h0010);
    vecs[1] = mk(16'h0000, 16'h0004, 1'b1, 16'h0010);
    vecs[2] = mk(16'hFF00, 16'hFF00, 1'b1, 16'hFF00);
    vecs[3] = mk(16'h0004, 16'h0004, 1'b1, 16'h0004);
    vecs[4] = mk(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF);
    vecs[5] = mk(16'h0001, 16'h0001, 1'b1, 16'h0001);
    vecs[6] = mk(16'h0000, 16'h0004, 1'b1, 16'h0001);
    vecs[7] = mk(16'h0000, 16'h0004, 1'b1, 16'h0001);

    // Reset held for 5 cycles with a nonzero din that must be ignored.
    sys_rst = 1'b1;
    bus.din = 16'h1234;
    repeat (5) @(posedge clk);
    #1;
    check16("rst.pc",   dut.PC,          16'h0000);
    check16("rst.dout", bus.dout,        16'h0000);
    check1 ("rst.trap", dut.trap_seen,   1'b0);
    check16("rst.last", dut.last_target, 16'h0000);

    // Release between edges; the first edge performs a normal update.
    sys_rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      apply($sformatf("vec%0d", i), vecs[i].din, vecs[i].exp);
    end

    // Reset asserted between edges takes effect without a clock.
    bus.din = 16'h5555;
    #3;
    sys_rst = 1'b1;
    #1;
    check16("async.pc",   dut.PC,          16'h0000);
    check16("async.dout", bus.dout,        16'h0000);
    check1 ("async.trap", dut.trap_seen,   1'b0);
    check16("async.last", dut.last_target, 16'h0000);
`ifdef BRANCH_STATS_EN
    check16("async.jcnt", dut.u_stats.jump_count, 16'h0000);
    check16("async.tcnt", dut.u_stats.trap_count, 16'h0000);
`endif
    // An edge under reset must not load din.
    @(posedge clk);
    #1;
    check16("hold.pc",   dut.PC,          16'h0000);
    check16("hold.last", dut.last_target, 16'h0000);
    sys_rst = 1'b0;

    // Target equal to the trap vector is a plain jump, flag stays clear.
    e.pc = 16'h0004; e.trap = 1'b0; e.last = 16'h0004;
    apply("tv_jump", 16'h0004, e);

    // Three jumps then two traps from a fresh reset.
    sys_rst = 1'b1;
    #2;
    sys_rst = 1'b0;
    e.pc = 16'h0100; e.trap = 1'b0; e.last = 16'h0100;
    apply("st0", 16'h0100, e);
    e.pc = 16'h0200; e.trap = 1'b0; e.last = 16'h0200;
    apply("st1", 16'h0200, e);
    e.pc = 16'h0300; e.trap = 1'b0; e.last = 16'h0300;
    apply("st2", 16'h0300, e);
    e.pc = 16'h0004; e.trap = 1'b1; e.last = 16'h0300;
    apply("st3", 16'h0000, e);
    e.pc = 16'h0004; e.trap = 1'b1; e.last = 16'h0300;
    apply("st4", 16'h0000, e);
`ifdef BRANCH_STATS_EN
    check16("stats.jcnt", dut.u_stats.jump_count, 16'd3);
    check16("stats.tcnt", dut.u_stats.trap_count, 16'd2);
`endif

    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d entries expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
